// File: rtl/smp_multi_core_if.sv
// -----------------------------------------------------------------------------
// smp_multi_core_if
//   Response stream from the challenge sequencer to its consumer.
//   A transfer happens on every clock edge where valid and ready are both high.
//
//   resp      NCH  per-channel response bits, meaningful while valid
//   unstable  NCH  per-channel disagreement flag across repeats
//   valid     1    response available
//   ready     1    consumer accepts the response
//
//   master : the producer (sequencer) drives resp/unstable/valid
//   slave  : the consumer drives ready
// -----------------------------------------------------------------------------
interface smp_multi_core_if #(
  parameter int NCH = 2
);
  logic [NCH-1:0] resp;
  logic [NCH-1:0] unstable;
  logic           valid;
  logic           ready;

  modport master (
    output resp,
    output unstable,
    output valid,
    input  ready
  );

  modport slave (
    input  resp,
    input  unstable,
    input  valid,
    output ready
  );
endinterface

// File: rtl/smp_multi_core.sv
// -----------------------------------------------------------------------------
// smp_multi_core
//   Challenge sequencer for multi-channel arbiter-PUF sampling. A run loads the
//   key into a W-bit LFSR, XORs in the seed and mixes for INIT_CYC steps, then
//   for each challenge flushes FLUSH_CYC more steps, arms the NCH external PUF
//   channels a number of times and emits either a per-channel majority vote
//   with an instability flag, or every raw evaluation.
//
//   clk        clock
//   rst_n      asynchronous active-low reset
//   i_go       start request (level, sampled in IDLE; must drop to leave DONE)
//   i_key      LFSR load value
//   i_seed     value XORed into the LFSR before mixing
//   i_nchl     challenges per run
//   i_nrpt     evaluations per challenge (0 behaves as 1)
//   i_mode     0 = majority vote, 1 = raw (one response per evaluation)
//   o_chl      current challenge (the LFSR state)
//   o_puf_arm  arm strobe to the PUF channels
//   i_puf_q    PUF channel outputs, sampled on the last arm cycle
//   rsp        response stream (master side of smp_multi_core_if)
//   o_busy     high in every state except IDLE
//   o_done     run complete; held until i_go drops
// -----------------------------------------------------------------------------
module smp_multi_core #(
  parameter int           W         = 56,
  parameter logic [W-1:0] POLY      = 56'hC0000600000000,
  parameter int           NCH       = 2,
  parameter int           INIT_CYC  = 112,
  parameter int           FLUSH_CYC = W,
  parameter int           SETTLE    = 8,
  parameter int           RPT_W     = 4,
  parameter int           CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_go,
  input  logic [W-1:0]     i_key,
  input  logic [W-1:0]     i_seed,
  input  logic [CNT_W-1:0] i_nchl,
  input  logic [RPT_W-1:0] i_nrpt,
  input  logic             i_mode,
  output logic [W-1:0]     o_chl,
  output logic             o_puf_arm,
  input  logic [NCH-1:0]   i_puf_q,
  smp_multi_core_if.master rsp,
  output logic             o_busy,
  output logic             o_done
);

  // One shared phase counter covers MIX, FLUSH, ARM and DISARM.
  localparam int CYC_MAX = (INIT_CYC > FLUSH_CYC)
                         ? ((INIT_CYC  > SETTLE) ? INIT_CYC  : SETTLE)
                         : ((FLUSH_CYC > SETTLE) ? FLUSH_CYC : SETTLE);
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  localparam logic [CYC_W-1:0] MIX_LAST    = CYC_W'(INIT_CYC);
  localparam logic [CYC_W-1:0] FLUSH_LAST  = CYC_W'(FLUSH_CYC - 1);
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_MIX,
    S_FLUSH,
    S_ARM,
    S_DISARM,
    S_EMIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           state;
  logic [W-1:0]     lfsr;
  logic [CYC_W-1:0] cyc;
  logic [RPT_W-1:0] rpt;
  logic [CNT_W-1:0] chl_cnt;
  logic [RPT_W:0]   ones [NCH];

  logic [RPT_W-1:0] n_eff;
  logic [RPT_W-1:0] rpt_inc;
  logic [NCH-1:0]   maj_resp;
  logic [NCH-1:0]   maj_unst;

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    return {s[W-2:0], ^(s & POLY)};
  endfunction

  assign n_eff   = (i_nrpt == '0) ? RPT_W'(1) : i_nrpt;
  assign rpt_inc = rpt + RPT_W'(1);
  assign o_chl   = lfsr;

  // Majority vote: strictly more than half the evaluations must be 1, so a
  // tie resolves to 0. A channel is unstable unless it was unanimous.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    maj_resp = '0;
    maj_unst = '0;
    for (int c = 0; c < NCH; c++) begin
      maj_resp[c] = ({ones[c], 1'b0} > {2'b00, n_eff});
      maj_unst[c] = (ones[c] != '0) && (ones[c] != {1'b0, n_eff});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: ones[] is a few small counters, not a RAM, so it is cleared by
      // reset along with every other register.
      state        <= S_IDLE;
      lfsr         <= '0;
      cyc          <= '0;
      rpt          <= '0;
      chl_cnt      <= '0;
      for (int c = 0; c < NCH; c++) ones[c] <= '0;
      o_puf_arm    <= 1'b0;
      rsp.resp     <= '0;
      rsp.unstable <= '0;
      rsp.valid    <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values of all others.
      case (state)
        S_IDLE: begin
          if (i_go) begin
            chl_cnt <= '0;
            o_busy  <= 1'b1;
            state   <= S_LOAD_KEY;
          end
        end

        S_LOAD_KEY: begin
          lfsr  <= i_key;
          cyc   <= '0;
          state <= S_MIX;
        end

        S_MIX: begin
          if (cyc == '0) lfsr <= lfsr ^ i_seed;
          else           lfsr <= lfsr_step(lfsr);
          if (cyc == MIX_LAST) begin
            cyc <= '0;
            if (i_nchl == '0) begin
              o_done <= 1'b1;
              state  <= S_DONE;
            end else begin
              state  <= S_FLUSH;
            end
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end

        S_FLUSH: begin
          lfsr <= lfsr_step(lfsr);
          rpt  <= '0;
          for (int c = 0; c < NCH; c++) ones[c] <= '0;
          if (cyc == FLUSH_LAST) begin
            cyc       <= '0;
            o_puf_arm <= 1'b1;
            state     <= S_ARM;
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end

        S_ARM: begin
          if (cyc == SETTLE_LAST) begin
            cyc       <= '0;
            o_puf_arm <= 1'b0;
            state     <= S_DISARM;
            if (i_mode) begin
              // Raw responses go straight to the output; valid is still low.
              rsp.resp <= i_puf_q;
            end else begin
              for (int c = 0; c < NCH; c++)
                ones[c] <= ones[c] + {{RPT_W{1'b0}}, i_puf_q[c]};
            end
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end

        S_DISARM: begin
          if (cyc == SETTLE_LAST) begin
            cyc <= '0;
            rpt <= rpt_inc;
            if (i_mode) begin
              rsp.unstable <= '0;
              rsp.valid    <= 1'b1;
              state        <= S_EMIT;
            end else if (rpt_inc == n_eff) begin
              rsp.resp     <= maj_resp;
              rsp.unstable <= maj_unst;
              rsp.valid    <= 1'b1;
              state        <= S_EMIT;
            end else begin
              o_puf_arm <= 1'b1;
              state     <= S_ARM;
            end
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end

        S_EMIT: begin
          if (rsp.ready) begin
            rsp.valid <= 1'b0;
            if (i_mode && (rpt != n_eff)) begin
              // Raw mode re-evaluates the same challenge without flushing.
              o_puf_arm <= 1'b1;
              state     <= S_ARM;
            end else begin
              chl_cnt <= chl_cnt + CNT_W'(1);
              state   <= S_NEXT;
            end
          end
        end

        S_NEXT: begin
          if (chl_cnt == i_nchl) begin
            o_done <= 1'b1;
            state  <= S_DONE;
          end else begin
            state  <= S_FLUSH;
          end
        end

        S_DONE: begin
          if (!i_go) begin
            o_done <= 1'b0;
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smp_multi_core.sv
// -----------------------------------------------------------------------------
// tb_smp_multi_core
//   Directed bench for smp_multi_core: a table of majority-vote runs with
//   hand-computed responses, plus sequences for raw mode, backpressure,
//   zero-challenge runs and a reset in the middle of an arm phase.
// -----------------------------------------------------------------------------
module tb_smp_multi_core;

  localparam int           W         = 56;
  localparam logic [W-1:0] POLY      = 56'hC0000600000000;
  localparam int           NCH       = 2;
  localparam int           INIT_CYC  = 112;
  localparam int           FLUSH_CYC = 56;
  localparam int           SETTLE    = 8;
  localparam int           RPT_W     = 4;
  localparam int           CNT_W     = 8;

  localparam int SIG_ARM   = 0;
  localparam int SIG_VALID = 1;
  localparam int SIG_DONE  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             go = 1'b0;
  logic [W-1:0]     key = '0;
  logic [W-1:0]     seed = '0;
  logic [CNT_W-1:0] nchl = '0;
  logic [RPT_W-1:0] nrpt = '0;
  logic             mode = 1'b0;
  logic [W-1:0]     chl;
  logic             arm;
  logic [NCH-1:0]   q = '0;
  logic             busy;
  logic             done;

  smp_multi_core_if #(.NCH(NCH)) rsp ();

  smp_multi_core #(
    .W(W), .POLY(POLY), .NCH(NCH), .INIT_CYC(INIT_CYC), .FLUSH_CYC(FLUSH_CYC),
    .SETTLE(SETTLE), .RPT_W(RPT_W), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_go      (go),
    .i_key     (key),
    .i_seed    (seed),
    .i_nchl    (nchl),
    .i_nrpt    (nrpt),
    .i_mode    (mode),
    .o_chl     (chl),
    .o_puf_arm (arm),
    .i_puf_q   (q),
    .rsp       (rsp),
    .o_busy    (busy),
    .o_done    (done)
  );

  always #5 clk = ~clk;

  // Free-running monitors; scenarios compare deltas, never reset these.
  int   cyc = 0;
  int   xfers = 0;
  int   valid_cycles = 0;
  int   arm_rises = 0;
  logic arm_q = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    arm_q <= arm;
    if (rsp.valid && rsp.ready) xfers <= xfers + 1;
    if (rsp.valid) valid_cycles <= valid_cycles + 1;
    if (arm && !arm_q) arm_rises <= arm_rises + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      SIG_ARM:   return arm;
      SIG_VALID: return rsp.valid;
      default:   return done;
    endcase
  endfunction

  // Waits (on negedges) until the selected output reaches lvl; an expired
  // budget counts as a failed comparison.
  task automatic wait_for(input int sel, input logic lvl, input string name, input int budget);
    int n = 0;
    while (sig(sel) !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sig(sel) !== lvl) begin
      errors++;
      $display("FAIL timeout %s: level %0b not reached in %0d cycles", name, lvl, budget);
    end
  endtask

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    return {s[W-2:0], ^(s & POLY)};
  endfunction

  // Golden challenge for challenge index idx of a run.
  function automatic logic [W-1:0] chl_model(input logic [W-1:0] k, input logic [W-1:0] sd,
                                             input int idx);
    logic [W-1:0] s;
    s = k ^ sd;
    for (int i = 0; i < INIT_CYC; i++) s = lfsr_step(s);
    for (int i = 0; i < FLUSH_CYC * (idx + 1); i++) s = lfsr_step(s);
    return s;
  endfunction

  typedef struct {
    logic [RPT_W-1:0] nrpt;
    logic [15:0]      q0;    // bit r = channel 0 output on evaluation r
    logic [15:0]      q1;    // bit r = channel 1 output on evaluation r
    logic [W-1:0]     key;
    logic [W-1:0]     seed;
    logic [1:0]       resp;
    logic [1:0]       unst;
  } vec_t;

  vec_t vecs [6];

  // One majority-mode single-challenge run, checked end to end.
  task automatic run_majority(input vec_t v, input int idx);
    int t0, x0, a0, n_eff, lat;
    string tag;
    tag = $sformatf("v%0d", idx);
    n_eff = (v.nrpt == 0) ? 1 : int'(v.nrpt);
    @(negedge clk);
    key = v.key; seed = v.seed; nrpt = v.nrpt; nchl = 8'd1; mode = 1'b0;
    rsp.ready = 1'b0; q = '0;
    t0 = cyc; x0 = xfers; a0 = arm_rises;
    go = 1'b1;
    for (int r = 0; r < n_eff; r++) begin
      wait_for(SIG_ARM, 1'b1, {tag, " arm high"}, 400);
      q = {v.q1[r], v.q0[r]};
      wait_for(SIG_ARM, 1'b0, {tag, " arm low"}, 20);
    end
    wait_for(SIG_VALID, 1'b1, {tag, " valid"}, 40);
    lat = cyc - t0 - 1;
    check({tag, " latency"}, lat, 2 + INIT_CYC + FLUSH_CYC + 2 * SETTLE * n_eff);
    check({tag, " resp"}, rsp.resp, v.resp);
    check({tag, " unstable"}, rsp.unstable, v.unst);
    check({tag, " chl"}, chl, chl_model(v.key, v.seed, 0));
    check({tag, " arm count"}, arm_rises - a0, n_eff);
    check({tag, " busy"}, busy, 1'b1);
    rsp.ready = 1'b1;
    @(negedge clk);
    check({tag, " valid drop"}, rsp.valid, 1'b0);
    rsp.ready = 1'b0;
    wait_for(SIG_DONE, 1'b1, {tag, " done"}, 10);
    check({tag, " transfers"}, xfers - x0, 1);
    repeat (5) @(negedge clk);
    check({tag, " done held"}, done, 1'b1);
    go = 1'b0;
    @(negedge clk);
    check({tag, " done clear"}, done, 1'b0);
    check({tag, " busy clear"}, busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]   pats [6];
    logic [1:0]   snap_resp;
    logic [W-1:0] snap_chl;
    int           bad, t0, x0, a0, v0;

    vecs[0] = '{4'd1,  16'h0000, 16'h0001, 56'h0,                 56'h1,                 2'b10, 2'b00};
    vecs[1] = '{4'd5,  16'h000B, 16'h0000, 56'h00A5_5A00_FF01_23, 56'h0F0F_0F0F_0F0F_0F, 2'b01, 2'b01};
    vecs[2] = '{4'd4,  16'h0003, 16'h000F, 56'h1234_5678_9ABC_DE, 56'h8000_0000_0000_01, 2'b10, 2'b01};
    vecs[3] = '{4'd0,  16'h0001, 16'h0000, 56'h00A5_5A00_FF01_23, 56'h8000_0000_0000_01, 2'b01, 2'b00};
    vecs[4] = '{4'd3,  16'h0001, 16'h0007, 56'h1234_5678_9ABC_DE, 56'h0F0F_0F0F_0F0F_0F, 2'b10, 2'b01};
    vecs[5] = '{4'd15, 16'h7FFF, 16'h007F, 56'hFFFF_FFFF_FFFF_FF, 56'h0F0F_0F0F_0F0F_0F, 2'b01, 2'b10};

    pats[0] = 2'b01; pats[1] = 2'b10; pats[2] = 2'b11;
    pats[3] = 2'b00; pats[4] = 2'b10; pats[5] = 2'b01;

    rsp.ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset chl", chl, '0);
    check("reset arm", arm, 1'b0);
    check("reset valid", rsp.valid, 1'b0);
    check("reset resp", rsp.resp, 2'b00);
    check("reset unstable", rsp.unstable, 2'b00);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Majority-vote table.
    for (int i = 0; i < 6; i++) run_majority(vecs[i], i);

    // Raw mode: 2 challenges x 3 evaluations, each transfer carries its sample.
    @(negedge clk);
    key = 56'h1234_5678_9ABC_DE; seed = 56'h8000_0000_0000_01;
    nrpt = 4'd3; nchl = 8'd2; mode = 1'b1; q = '0;
    x0 = xfers;
    go = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_for(SIG_ARM, 1'b1, $sformatf("raw%0d arm", k), 400);
      q = pats[k];
      wait_for(SIG_VALID, 1'b1, $sformatf("raw%0d valid", k), 40);
      check($sformatf("raw%0d resp", k), rsp.resp, pats[k]);
      check($sformatf("raw%0d unstable", k), rsp.unstable, 2'b00);
      check($sformatf("raw%0d chl", k), chl, chl_model(key, seed, k / 3));
      rsp.ready = 1'b1;
      @(negedge clk);
      check($sformatf("raw%0d valid drop", k), rsp.valid, 1'b0);
      rsp.ready = 1'b0;
    end
    wait_for(SIG_DONE, 1'b1, "raw done", 10);
    check("raw transfers", xfers - x0, 6);
    go = 1'b0;
    mode = 1'b0;
    @(negedge clk);

    // Backpressure: ready held low 20 cycles in EMIT.
    key = 56'h00A5_5A00_FF01_23; seed = 56'h1; nrpt = 4'd2; nchl = 8'd1; q = 2'b11;
    go = 1'b1;
    wait_for(SIG_VALID, 1'b1, "bp valid", 800);
    snap_resp = rsp.resp;
    snap_chl  = chl;
    check("bp resp", snap_resp, 2'b11);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp.valid !== 1'b1 || rsp.resp !== snap_resp || chl !== snap_chl) bad++;
    end
    check("bp held cycles bad", bad, 0);
    rsp.ready = 1'b1;
    @(negedge clk);
    check("bp valid drop", rsp.valid, 1'b0);
    rsp.ready = 1'b0;
    wait_for(SIG_DONE, 1'b1, "bp done", 10);
    go = 1'b0;
    @(negedge clk);

    // Zero challenges: done straight after mixing, no arm, no valid.
    nchl = 8'd0; nrpt = 4'd0; q = 2'b00;
    t0 = cyc; a0 = arm_rises; v0 = valid_cycles;
    go = 1'b1;
    wait_for(SIG_DONE, 1'b1, "nchl0 done", 300);
    check("nchl0 latency", cyc - t0 - 1, 2 + INIT_CYC);
    check("nchl0 valid cycles", valid_cycles - v0, 0);
    check("nchl0 arm count", arm_rises - a0, 0);
    repeat (3) @(negedge clk);
    check("nchl0 done held", done, 1'b1);
    go = 1'b0;
    @(negedge clk);
    check("nchl0 done clear", done, 1'b0);

    // Reset asserted mid-ARM, then a clean restart.
    nchl = 8'd1; nrpt = 4'd2;
    go = 1'b1;
    wait_for(SIG_ARM, 1'b1, "rst arm", 400);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst arm", arm, 1'b0);
    check("rst valid", rsp.valid, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst chl", chl, '0);
    go = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst idle busy", busy, 1'b0);
    run_majority(vecs[0], 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
